// File: rtl/fp_issue_pkg.sv
// Shared types and constants for the FP issue/collect engine.
package fp_issue_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } fp_state_e;

   localparam int CH_ADDSUB = 0;
   localparam int CH_MUL    = 1;
   localparam int CH_DIV    = 2;
   localparam int CH_COMP   = 3;

   localparam logic [7:0] OP_ADD = 8'h00;
   localparam logic [7:0] OP_SUB = 8'h01;
   localparam logic [7:0] OP_EQ  = 8'h14;
   localparam logic [7:0] OP_LT  = 8'h0C;
   localparam logic [7:0] OP_LE  = 8'h1C;

endpackage

// File: rtl/fp_issue_skid.sv
// Single-stream TVALID/TDATA holding register: loaded on issue, valid drops on its own TREADY.
module fp_issue_skid #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic         load_en,
   input  logic [W-1:0] load_data,
   input  logic         tready,
   output logic         tvalid,
   output logic [W-1:0] tdata
);

   always_ff @(posedge CLK) begin
      if (RST) begin
         tvalid <= 1'b0;
         tdata  <= '0;
      end else if (load) begin
         tvalid <= load_en;
         tdata  <= load_data;
      end else if (tvalid && tready) begin
         tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/fp_issue_unit.sv
// Single-issue engine: drives operand/opcode streams of the selected FP unit and returns its result.
// Build macro FP_ISSUE_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles.
//
// state | meaning
// IDLE  | ready for a request; drains any stale unit results
// SEND  | operand/opcode streams valid until each is accepted
// WAIT  | waiting for the selected unit's result
// RESP  | response held for the core until RESP_READY
module fp_issue_unit
   import fp_issue_pkg::*;
#(
   parameter int NCH = 4,
   parameter int DW  = 32,
   parameter int OPW = 8,
   parameter logic [NCH-1:0] OP_MASK = 4'b1001,
`ifdef FP_ISSUE_TIMEOUT_EN
   parameter int TIMEOUT = 255,
`endif
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               REQ_VALID,
   output logic               REQ_READY,
   input  logic [CHW-1:0]     REQ_CH,
   input  logic [DW-1:0]      REQ_A,
   input  logic [DW-1:0]      REQ_B,
   input  logic [OPW-1:0]     REQ_OP,
   output logic [NCH*DW-1:0]  A_TDATA,
   output logic [NCH-1:0]     A_TVALID,
   input  logic [NCH-1:0]     A_TREADY,
   output logic [NCH*DW-1:0]  B_TDATA,
   output logic [NCH-1:0]     B_TVALID,
   input  logic [NCH-1:0]     B_TREADY,
   output logic [NCH*OPW-1:0] OP_TDATA,
   output logic [NCH-1:0]     OP_TVALID,
   input  logic [NCH-1:0]     OP_TREADY,
   input  logic [NCH*DW-1:0]  R_TDATA,
   input  logic [NCH-1:0]     R_TVALID,
   output logic [NCH-1:0]     R_TREADY,
   output logic               RESP_VALID,
   input  logic               RESP_READY,
   output logic [DW-1:0]      RESP_DATA,
   output logic [CHW-1:0]     RESP_CH,
   output logic               RESP_ERR,
   output logic               BUSY
);

   fp_state_e      state_q, state_d;
   logic [CHW-1:0] ch_q;
   logic           req_ch_ok, req_op_en, load;
   logic           a_vld, b_vld, op_vld;
   logic           a_rdy, b_rdy, op_rdy, r_vld;
   logic [DW-1:0]  a_dat, b_dat, r_dat;
   logic [OPW-1:0] op_dat;
   logic           tmo_hit;

   assign REQ_READY = (state_q == IDLE);
   assign BUSY      = (state_q != IDLE);
   assign load      = REQ_VALID && (state_q == IDLE);

   always_comb begin
      req_ch_ok = 1'b0;
      req_op_en = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (REQ_CH == CHW'(i)) begin
            req_ch_ok = 1'b1;
            req_op_en = OP_MASK[i];
         end
      end
   end

   fp_issue_skid #(.W(DW)) u_skid_a (
      .CLK(CLK), .RST(RST), .load(load), .load_en(req_ch_ok), .load_data(REQ_A),
      .tready(a_rdy), .tvalid(a_vld), .tdata(a_dat)
   );

   fp_issue_skid #(.W(DW)) u_skid_b (
      .CLK(CLK), .RST(RST), .load(load), .load_en(req_ch_ok), .load_data(REQ_B),
      .tready(b_rdy), .tvalid(b_vld), .tdata(b_dat)
   );

   fp_issue_skid #(.W(OPW)) u_skid_op (
      .CLK(CLK), .RST(RST), .load(load), .load_en(req_ch_ok && req_op_en), .load_data(REQ_OP),
      .tready(op_rdy), .tvalid(op_vld), .tdata(op_dat)
   );

   // A bad channel latched in ch_q matches no index, so nothing fans out.
   always_comb begin
      a_rdy     = 1'b0;
      b_rdy     = 1'b0;
      op_rdy    = 1'b0;
      r_vld     = 1'b0;
      r_dat     = '0;
      A_TVALID  = '0;
      B_TVALID  = '0;
      OP_TVALID = '0;
      A_TDATA   = '0;
      B_TDATA   = '0;
      OP_TDATA  = '0;
      R_TREADY  = '0;
      if (state_q == IDLE)
         R_TREADY = '1;
      for (int i = 0; i < NCH; i++) begin
         if (ch_q == CHW'(i)) begin
            a_rdy                  = A_TREADY[i];
            b_rdy                  = B_TREADY[i];
            op_rdy                 = OP_TREADY[i];
            r_vld                  = R_TVALID[i] && (state_q == WAIT);
            r_dat                  = R_TDATA[i*DW +: DW];
            A_TVALID[i]            = a_vld;
            B_TVALID[i]            = b_vld;
            A_TDATA[i*DW +: DW]    = a_dat;
            B_TDATA[i*DW +: DW]    = b_dat;
            if (OP_MASK[i]) begin
               OP_TVALID[i]           = op_vld;
               OP_TDATA[i*OPW +: OPW] = op_dat;
            end
            if (state_q == WAIT)
               R_TREADY[i] = 1'b1;
         end
      end
   end

`ifdef FP_ISSUE_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [TW-1:0] tmo_cnt_q;

   // Counter holds the number of WAIT cycles already completed; fires on the TIMEOUT-th.
   always_ff @(posedge CLK) begin
      if (RST || (state_q != WAIT))
         tmo_cnt_q <= '0;
      else
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end

   assign tmo_hit = (state_q == WAIT) && (tmo_cnt_q == TW'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (REQ_VALID) state_d = req_ch_ok ? SEND : RESP;
         SEND:    if ((!a_vld || a_rdy) && (!b_vld || b_rdy) && (!op_vld || op_rdy))
                     state_d = WAIT;
         WAIT:    if (r_vld || tmo_hit) state_d = RESP;
         RESP:    if (RESP_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         RESP_VALID <= 1'b0;
         RESP_DATA  <= '0;
         RESP_ERR   <= 1'b0;
         RESP_CH    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            ch_q <= REQ_CH;
            if (!req_ch_ok) begin
               RESP_VALID <= 1'b1;
               RESP_DATA  <= '0;
               RESP_ERR   <= 1'b1;
               RESP_CH    <= REQ_CH;
            end
         end
         if (r_vld) begin
            RESP_VALID <= 1'b1;
            RESP_DATA  <= r_dat;
            RESP_ERR   <= 1'b0;
            RESP_CH    <= ch_q;
         end else if (tmo_hit) begin
            RESP_VALID <= 1'b1;
            RESP_DATA  <= '0;
            RESP_ERR   <= 1'b1;
            RESP_CH    <= ch_q;
         end
         if ((state_q == RESP) && RESP_READY)
            RESP_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_issue_unit.sv
// Scoreboard bench for fp_issue_unit: directed requests push expected responses, a monitor pops them.
module tb_fp_issue_unit;
   import fp_issue_pkg::*;

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic         REQ_VALID, REQ_READY, RESP_VALID, RESP_READY, RESP_ERR, BUSY;
   logic [1:0]   REQ_CH, RESP_CH;
   logic [31:0]  REQ_A, REQ_B, RESP_DATA;
   logic [7:0]   REQ_OP;
   logic [127:0] A_TDATA, B_TDATA, R_TDATA;
   logic [31:0]  OP_TDATA;
   logic [3:0]   A_TVALID, A_TREADY, B_TVALID, B_TREADY, OP_TVALID, OP_TREADY;
   logic [3:0]   R_TVALID, R_TREADY;

   logic         d3_REQ_VALID, d3_REQ_READY, d3_RESP_VALID, d3_RESP_READY, d3_RESP_ERR, d3_BUSY;
   logic [1:0]   d3_REQ_CH, d3_RESP_CH;
   logic [31:0]  d3_REQ_A, d3_REQ_B, d3_RESP_DATA;
   logic [7:0]   d3_REQ_OP;
   logic [95:0]  d3_A_TDATA, d3_B_TDATA, d3_R_TDATA;
   logic [23:0]  d3_OP_TDATA;
   logic [2:0]   d3_A_TVALID, d3_A_TREADY, d3_B_TVALID, d3_B_TREADY, d3_OP_TVALID, d3_OP_TREADY;
   logic [2:0]   d3_R_TVALID, d3_R_TREADY;

   exp_t sb[$];
   exp_t sb3[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   fp_issue_unit #(
`ifdef FP_ISSUE_TIMEOUT_EN
      .TIMEOUT(8),
`endif
      .NCH(4), .DW(32), .OPW(8), .OP_MASK(4'b1001)
   ) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CH(REQ_CH),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_OP(REQ_OP),
      .A_TDATA(A_TDATA), .A_TVALID(A_TVALID), .A_TREADY(A_TREADY),
      .B_TDATA(B_TDATA), .B_TVALID(B_TVALID), .B_TREADY(B_TREADY),
      .OP_TDATA(OP_TDATA), .OP_TVALID(OP_TVALID), .OP_TREADY(OP_TREADY),
      .R_TDATA(R_TDATA), .R_TVALID(R_TVALID), .R_TREADY(R_TREADY),
      .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA),
      .RESP_CH(RESP_CH), .RESP_ERR(RESP_ERR), .BUSY(BUSY)
   );

   // Three-channel instance: its 2-bit REQ_CH can encode an out-of-range channel.
   fp_issue_unit #(
      .NCH(3), .DW(32), .OPW(8), .OP_MASK(3'b001)
   ) dut3 (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(d3_REQ_VALID), .REQ_READY(d3_REQ_READY), .REQ_CH(d3_REQ_CH),
      .REQ_A(d3_REQ_A), .REQ_B(d3_REQ_B), .REQ_OP(d3_REQ_OP),
      .A_TDATA(d3_A_TDATA), .A_TVALID(d3_A_TVALID), .A_TREADY(d3_A_TREADY),
      .B_TDATA(d3_B_TDATA), .B_TVALID(d3_B_TVALID), .B_TREADY(d3_B_TREADY),
      .OP_TDATA(d3_OP_TDATA), .OP_TVALID(d3_OP_TVALID), .OP_TREADY(d3_OP_TREADY),
      .R_TDATA(d3_R_TDATA), .R_TVALID(d3_R_TVALID), .R_TREADY(d3_R_TREADY),
      .RESP_VALID(d3_RESP_VALID), .RESP_READY(d3_RESP_READY), .RESP_DATA(d3_RESP_DATA),
      .RESP_CH(d3_RESP_CH), .RESP_ERR(d3_RESP_ERR), .BUSY(d3_BUSY)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic send_req(input logic [1:0] ch, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] op);
      chk("req_ready_idle", 64'(REQ_READY), 64'h1);
      REQ_VALID = 1'b1; REQ_CH = ch; REQ_A = a; REQ_B = b; REQ_OP = op;
      tick;
      REQ_VALID = 1'b0; REQ_A = '0; REQ_B = '0; REQ_OP = '0;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (RESP_VALID && RESP_READY) begin
         if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_unexpected: got response data %0h with nothing expected", RESP_DATA);
         end else begin
            e = sb.pop_front();
            chk("resp_ch",   64'(RESP_CH),   64'(e.ch));
            chk("resp_data", 64'(RESP_DATA), 64'(e.data));
            chk("resp_err",  64'(RESP_ERR),  64'(e.err));
         end
      end
      if (d3_RESP_VALID && d3_RESP_READY) begin
         if (sb3.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb3_unexpected: got response data %0h with nothing expected", d3_RESP_DATA);
         end else begin
            e = sb3.pop_front();
            chk("d3_resp_ch",   64'(d3_RESP_CH),   64'(e.ch));
            chk("d3_resp_data", 64'(d3_RESP_DATA), 64'(e.data));
            chk("d3_resp_err",  64'(d3_RESP_ERR),  64'(e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1);
   end

   initial begin
      RST = 1'b1;
      REQ_VALID = 1'b0; REQ_CH = '0; REQ_A = '0; REQ_B = '0; REQ_OP = '0;
      A_TREADY = '0; B_TREADY = '0; OP_TREADY = '0; R_TVALID = '0; R_TDATA = '0;
      RESP_READY = 1'b0;
      d3_REQ_VALID = 1'b0; d3_REQ_CH = '0; d3_REQ_A = '0; d3_REQ_B = '0; d3_REQ_OP = '0;
      d3_A_TREADY = '0; d3_B_TREADY = '0; d3_OP_TREADY = '0; d3_R_TVALID = '0; d3_R_TDATA = '0;
      d3_RESP_READY = 1'b0;
      tick; tick;

      chk("rst_busy",       64'(BUSY),       64'h0);
      chk("rst_req_ready",  64'(REQ_READY),  64'h1);
      chk("rst_resp_valid", 64'(RESP_VALID), 64'h0);
      chk("rst_resp_data",  64'(RESP_DATA),  64'h0);
      chk("rst_a_tvalid",   64'(A_TVALID),   64'h0);
      chk("rst_op_tvalid",  64'(OP_TVALID),  64'h0);
      chk("rst_r_tready",   64'(R_TREADY),   64'hF);
      RST = 1'b0;
      tick;

      // fadd 1.0 + 2.0, all readies high, minimum round trip
      A_TREADY = '1; B_TREADY = '1; OP_TREADY = '1; RESP_READY = 1'b1;
      sb.push_back('{2'd0, 32'h40400000, 1'b0});
      send_req(2'(CH_ADDSUB), 32'h3F800000, 32'h40000000, OP_ADD);
      chk("fadd_a_tvalid",  64'(A_TVALID),        64'h1);
      chk("fadd_b_tvalid",  64'(B_TVALID),        64'h1);
      chk("fadd_op_tvalid", 64'(OP_TVALID),       64'h1);
      chk("fadd_a_tdata",   64'(A_TDATA[31:0]),   64'h3F800000);
      chk("fadd_b_tdata",   64'(B_TDATA[31:0]),   64'h40000000);
      chk("fadd_op_tdata",  64'(OP_TDATA[7:0]),   64'(OP_ADD));
      chk("fadd_busy",      64'(BUSY),            64'h1);
      chk("fadd_req_ready", 64'(REQ_READY),       64'h0);
      tick;
      chk("fadd_r_tready",  64'(R_TREADY),        64'h1);
      chk("fadd_a_dropped", 64'(A_TVALID),        64'h0);
      chk("fadd_no_resp",   64'(RESP_VALID),      64'h0);
      R_TVALID = 4'b0001; R_TDATA[31:0] = 32'h40400000;
      tick;
      chk("fadd_resp_valid", 64'(RESP_VALID),     64'h1);
      R_TVALID = '0;
      tick;
      chk("fadd_resp_done", 64'(RESP_VALID),      64'h0);
      chk("fadd_idle",      64'(BUSY),            64'h0);

      // div 6.0 / 2.0 with staggered readies, no OP stream on channel 2
      A_TREADY = '0; B_TREADY = '0; OP_TREADY = '0;
      sb.push_back('{2'd2, 32'h40400000, 1'b0});
      send_req(2'(CH_DIV), 32'h40C00000, 32'h40000000, OP_SUB);
      chk("div_a_tvalid",  64'(A_TVALID),          64'h4);
      chk("div_b_tvalid",  64'(B_TVALID),          64'h4);
      chk("div_op_tvalid", 64'(OP_TVALID),         64'h0);
      chk("div_a_tdata",   64'(A_TDATA[64 +: 32]), 64'h40C00000);
      A_TREADY[2] = 1'b1;
      tick;
      A_TREADY = '0;
      chk("div_a_dropped", 64'(A_TVALID),          64'h0);
      chk("div_b_held",    64'(B_TVALID),          64'h4);
      chk("div_send_rtr",  64'(R_TREADY),          64'h0);
      for (int i = 2; i <= 3; i++) begin
         tick;
         chk("div_b_held",    64'(B_TVALID),          64'h4);
         chk("div_b_stable",  64'(B_TDATA[64 +: 32]), 64'h40000000);
         chk("div_send_rtr",  64'(R_TREADY),          64'h0);
         chk("div_op_tvalid", 64'(OP_TVALID),         64'h0);
      end
      B_TREADY[2] = 1'b1;
      tick;
      B_TREADY = '0;
      chk("div_b_dropped", 64'(B_TVALID),          64'h0);
      chk("div_wait_rtr",  64'(R_TREADY),          64'h4);
      R_TVALID = 4'b0100; R_TDATA[64 +: 32] = 32'h40400000;
      tick;
      chk("div_resp_valid", 64'(RESP_VALID),       64'h1);
      R_TVALID = '0;
      tick;
      chk("div_idle",       64'(BUSY),             64'h0);

      // comp 1.0 < 2.0 with response backpressure
      A_TREADY = '1; B_TREADY = '1; OP_TREADY = '1; RESP_READY = 1'b0;
      sb.push_back('{2'd3, 32'h00000001, 1'b0});
      send_req(2'(CH_COMP), 32'h3F800000, 32'h40000000, OP_LT);
      chk("bp_op_tvalid", 64'(OP_TVALID),         64'h8);
      chk("bp_op_tdata",  64'(OP_TDATA[24 +: 8]), 64'(OP_LT));
      tick;
      R_TVALID = 4'b1000; R_TDATA[96 +: 32] = 32'h00000001;
      tick;
      R_TVALID = '0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_resp_valid", 64'(RESP_VALID), 64'h1);
         chk("bp_resp_data",  64'(RESP_DATA),  64'h1);
         chk("bp_req_ready",  64'(REQ_READY),  64'h0);
         chk("bp_busy",       64'(BUSY),       64'h1);
         tick;
      end
      RESP_READY = 1'b1;
      tick;
      chk("bp_resp_done", 64'(RESP_VALID), 64'h0);
      chk("bp_idle",      64'(BUSY),       64'h0);

      // out-of-range channel on the three-channel instance
      d3_RESP_READY = 1'b1;
      sb3.push_back('{2'd3, 32'h0, 1'b1});
      chk("bad_req_ready", 64'(d3_REQ_READY), 64'h1);
      d3_REQ_VALID = 1'b1; d3_REQ_CH = 2'd3; d3_REQ_A = 32'h3F800000;
      d3_REQ_B = 32'h3F800000; d3_REQ_OP = OP_EQ;
      tick;
      d3_REQ_VALID = 1'b0;
      chk("bad_a_tvalid",   64'(d3_A_TVALID),   64'h0);
      chk("bad_b_tvalid",   64'(d3_B_TVALID),   64'h0);
      chk("bad_op_tvalid",  64'(d3_OP_TVALID),  64'h0);
      chk("bad_resp_valid", 64'(d3_RESP_VALID), 64'h1);
      tick;
      chk("bad_resp_done",  64'(d3_RESP_VALID), 64'h0);
      chk("bad_idle",       64'(d3_BUSY),       64'h0);

`ifdef FP_ISSUE_TIMEOUT_EN
      // no result: abort after exactly 8 WAIT cycles, late result drained in IDLE
      sb.push_back('{2'd1, 32'h0, 1'b1});
      send_req(2'(CH_MUL), 32'h3FC00000, 32'h40000000, OP_LE);
      tick;
      for (int i = 1; i <= 7; i++) begin
         tick;
         chk("tmo_early_resp", 64'(RESP_VALID), 64'h0);
      end
      tick;
      chk("tmo_resp_valid", 64'(RESP_VALID), 64'h1);
      chk("tmo_resp_err",   64'(RESP_ERR),   64'h1);
      tick;
      chk("tmo_idle",       64'(BUSY),       64'h0);
      R_TVALID = 4'b0010; R_TDATA[32 +: 32] = 32'h40400000;
      chk("tmo_drain_rtr",  64'(R_TREADY),   64'hF);
      tick;
      chk("tmo_drain_resp", 64'(RESP_VALID), 64'h0);
      chk("tmo_drain_busy", 64'(BUSY),       64'h0);
      R_TVALID = '0;
`else
      // no timeout build: WAIT holds until the unit answers
      sb.push_back('{2'd1, 32'h40400000, 1'b0});
      send_req(2'(CH_MUL), 32'h3FC00000, 32'h40000000, OP_LE);
      tick;
      for (int i = 0; i < 20; i++) tick;
      chk("wait_no_resp", 64'(RESP_VALID), 64'h0);
      chk("wait_busy",    64'(BUSY),       64'h1);
      chk("wait_rtr",     64'(R_TREADY),   64'h2);
      R_TVALID = 4'b0010; R_TDATA[32 +: 32] = 32'h40400000;
      tick;
      chk("wait_resp_valid", 64'(RESP_VALID), 64'h1);
      R_TVALID = '0;
      tick;
      chk("wait_idle", 64'(BUSY), 64'h0);
`endif

      // reset while in WAIT, then a clean fmul 2.0 * 3.0
      send_req(2'(CH_MUL), 32'h40000000, 32'h40400000, OP_ADD);
      tick;
      chk("rw_wait_rtr", 64'(R_TREADY), 64'h2);
      RST = 1'b1;
      tick;
      chk("rw_a_tvalid",   64'(A_TVALID),   64'h0);
      chk("rw_b_tvalid",   64'(B_TVALID),   64'h0);
      chk("rw_a_tdata",    64'(A_TDATA[63:0]), 64'h0);
      chk("rw_r_tready",   64'(R_TREADY),   64'hF);
      chk("rw_resp_valid", 64'(RESP_VALID), 64'h0);
      chk("rw_resp_data",  64'(RESP_DATA),  64'h0);
      chk("rw_resp_err",   64'(RESP_ERR),   64'h0);
      chk("rw_resp_ch",    64'(RESP_CH),    64'h0);
      chk("rw_busy",       64'(BUSY),       64'h0);
      RST = 1'b0;
      R_TVALID = 4'b0010; R_TDATA[32 +: 32] = 32'hDEADBEEF;
      tick;
      chk("rw_drain_resp", 64'(RESP_VALID), 64'h0);
      R_TVALID = '0;
      sb.push_back('{2'd1, 32'h40C00000, 1'b0});
      send_req(2'(CH_MUL), 32'h40000000, 32'h40400000, OP_ADD);
      tick;
      R_TVALID = 4'b0010; R_TDATA[32 +: 32] = 32'h40C00000;
      tick;
      chk("fmul_resp_valid", 64'(RESP_VALID), 64'h1);
      R_TVALID = '0;
      tick;
      chk("fmul_idle", 64'(BUSY), 64'h0);

      tick;
      chk("sb_empty", 64'(sb.size() + sb3.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
